// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary-encoder frequency selector.
package rotary_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CW1,
    CW2,
    CW3,
    CCW1,
    CCW2,
    CCW3,
    ERR
  } rot_state_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam logic [1:0] DETENT_AB = 2'b11;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// Resets to level 1, which matches the encoder's resting detent.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state here is registered with <= so every flop samples the
  // pre-edge value of its neighbours; blocking assignments would collapse
  // the synchroniser chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] != stable) begin
        // The sample that hits the last count is itself the final stable one.
        if (cnt == CNT_LAST) begin
          stable <= sync_q[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rotary_freq_selector.sv
// Rotary-encoder front end: debounced quadrature decode into a saturating
// frequency-select value with step and change pulses.
module rotary_freq_selector
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SEL_W           = 4,
  parameter int SEL_MAX         = 15,
  parameter int SEL_RESET       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clk_in,
  input  logic             dt_in,
  output logic [SEL_W-1:0] freq_sel,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             sel_changed
);

  localparam logic [SEL_W-1:0] SEL_TOP  = SEL_W'(SEL_MAX);
  localparam logic [SEL_W-1:0] SEL_INIT = SEL_W'(SEL_RESET);

  logic       a_db;
  logic       b_db;
  logic [1:0] ab;
  logic [1:0] ab_prev;
  logic       ab_changed;

  rot_state_e       state, state_next;
  logic             step_fire;
  logic             step_cw;
  logic             dir_next;
  logic [SEL_W-1:0] sel_next;
  logic             changed_next;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk    (clk),
    .rst    (rst),
    .raw    (clk_in),
    .stable (a_db)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk    (clk),
    .rst    (rst),
    .raw    (dt_in),
    .stable (b_db)
  );

  assign ab         = {a_db, b_db};
  assign ab_changed = (ab != ab_prev);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    step_fire    = 1'b0;
    step_cw      = 1'b0;
    dir_next     = step_dir;
    sel_next     = freq_sel;
    changed_next = 1'b0;

    if (ena && ab_changed) begin
      case (state)
        IDLE: begin
          case (ab)
            2'b01:   state_next = CW1;
            2'b10:   state_next = CCW1;
            2'b00:   state_next = ERR;
            default: state_next = IDLE;
          endcase
        end
        CW1: begin
          case (ab)
            2'b00:     state_next = CW2;
            DETENT_AB: state_next = IDLE;
            default:   state_next = ERR;
          endcase
        end
        CW2: begin
          case (ab)
            2'b10:     state_next = CW3;
            2'b01:     state_next = CW1;
            DETENT_AB: state_next = IDLE;
            default:   state_next = ERR;
          endcase
        end
        CW3: begin
          case (ab)
            DETENT_AB: begin
              state_next = IDLE;
              step_fire  = 1'b1;
              step_cw    = 1'b1;
            end
            2'b00:   state_next = CW2;
            default: state_next = ERR;
          endcase
        end
        CCW1: begin
          case (ab)
            2'b00:     state_next = CCW2;
            DETENT_AB: state_next = IDLE;
            default:   state_next = ERR;
          endcase
        end
        CCW2: begin
          case (ab)
            2'b01:     state_next = CCW3;
            2'b10:     state_next = CCW1;
            DETENT_AB: state_next = IDLE;
            default:   state_next = ERR;
          endcase
        end
        CCW3: begin
          case (ab)
            DETENT_AB: begin
              state_next = IDLE;
              step_fire  = 1'b1;
              step_cw    = 1'b0;
            end
            2'b00:   state_next = CCW2;
            default: state_next = ERR;
          endcase
        end
        ERR: begin
          if (ab == DETENT_AB) state_next = IDLE;
        end
      endcase
    end

    if (step_fire) begin
      dir_next = step_cw ? DIR_CW : DIR_CCW;
      if (step_cw) begin
        if (freq_sel != SEL_TOP) sel_next = freq_sel + SEL_W'(1);
      end else begin
        if (freq_sel != '0) sel_next = freq_sel - SEL_W'(1);
      end
      changed_next = (sel_next != freq_sel);
    end
  end

  // ab_prev tracks even while disabled so edges seen with ena low are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ab_prev     <= DETENT_AB;
      state       <= IDLE;
      freq_sel    <= SEL_INIT;
      step_pulse  <= 1'b0;
      step_dir    <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      ab_prev     <= ab;
      state       <= state_next;
      freq_sel    <= sel_next;
      step_pulse  <= step_fire;
      step_dir    <= dir_next;
      sel_changed <= changed_next;
    end
  end

endmodule

// File: tb/tb_rotary_freq_selector.sv
// Directed bench for rotary_freq_selector with DEBOUNCE_CYCLES = 4.
module tb_rotary_freq_selector;
  import rotary_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       clk_in = 1'b1;
  logic       dt_in = 1'b1;
  logic [3:0] freq_sel;
  logic       step_pulse;
  logic       step_dir;
  logic       sel_changed;

  int checks = 0;
  int errors = 0;

  int cyc        = 0;
  int last_drive = 0;
  int steps      = 0;
  int cw_steps   = 0;
  int changes    = 0;
  int step_cyc   = 0;
  int wide       = 0;
  int a_edges    = 0;
  logic prev_step = 1'b0;
  logic prev_chg  = 1'b0;
  logic prev_a_db = 1'b1;

  rotary_freq_selector #(
    .DEBOUNCE_CYCLES (DEB),
    .SEL_W           (4),
    .SEL_MAX         (15),
    .SEL_RESET       (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .clk_in      (clk_in),
    .dt_in       (dt_in),
    .freq_sel    (freq_sel),
    .step_pulse  (step_pulse),
    .step_dir    (step_dir),
    .sel_changed (sel_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    prev_step <= step_pulse;
    prev_chg  <= sel_changed;
    prev_a_db <= dut.a_db;
    if (!rst && dut.a_db != prev_a_db) a_edges <= a_edges + 1;
    if (step_pulse) begin
      steps    <= steps + 1;
      step_cyc <= cyc;
      if (step_dir) cw_steps <= cw_steps + 1;
    end
    if (sel_changed) changes <= changes + 1;
    if ((step_pulse && prev_step) || (sel_changed && prev_chg)) wide <= wide + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] v);
    @(posedge clk);
    #1;
    {clk_in, dt_in} = v;
    last_drive = cyc;
  endtask

  task automatic hold_ab(input logic [1:0] v, input int n);
    set_ab(v);
    wait_cyc(n);
  endtask

  task automatic detent(input logic cw);
    if (cw) begin
      hold_ab(2'b01, 8); hold_ab(2'b00, 8); hold_ab(2'b10, 8); hold_ab(2'b11, 8);
    end else begin
      hold_ab(2'b10, 8); hold_ab(2'b00, 8); hold_ab(2'b01, 8); hold_ab(2'b11, 8);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cyc(n);
    rst = 1'b0;
  endtask

  int s0, c0, e0;

  initial begin
    // Reset
    do_reset(3);
    check("rst_freq_sel", freq_sel, 1);
    check("rst_step_pulse", step_pulse, 0);
    check("rst_sel_changed", sel_changed, 0);
    check("rst_step_dir", step_dir, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    wait_cyc(4);

    // One clean CW detent, with latency from the final 11 capture edge
    hold_ab(2'b01, 10); hold_ab(2'b00, 10); hold_ab(2'b10, 10);
    set_ab(2'b11);
    s0 = last_drive;
    wait_cyc(10);
    check("cw_steps", steps, 1);
    check("cw_dir", cw_steps, 1);
    check("cw_freq_sel", freq_sel, 2);
    check("cw_changed", changes, 1);
    check("cw_latency", step_cyc - (s0 + 1), 2 + DEB);

    // Bounce on A, then settle at 0
    s0 = steps; e0 = a_edges;
    for (int i = 0; i < 6; i++) hold_ab({1'(i % 2), 1'b1}, 1);
    hold_ab(2'b01, 4);
    check("bounce_early", a_edges - e0, 0);
    wait_cyc(8);
    check("bounce_edges", a_edges - e0, 1);
    check("bounce_state", 32'(dut.state), 32'(CW1));
    hold_ab(2'b11, 10);
    check("bounce_idle", 32'(dut.state), 32'(IDLE));
    check("bounce_steps", steps - s0, 0);
    check("bounce_freq_sel", freq_sel, 2);

    // Saturation upward then downward
    do_reset(1);
    wait_cyc(4);
    s0 = steps; c0 = changes;
    for (int i = 0; i < 14; i++) detent(1'b1);
    check("sat14_changes", changes - c0, 14);
    check("sat14_freq_sel", freq_sel, 15);
    detent(1'b1); detent(1'b1);
    check("sat_hi_freq_sel", freq_sel, 15);
    check("sat_hi_steps", steps - s0, 16);
    check("sat_hi_changes", changes - c0, 14);
    s0 = steps; c0 = changes; e0 = cw_steps;
    for (int i = 0; i < 20; i++) detent(1'b0);
    check("sat_lo_freq_sel", freq_sel, 0);
    check("sat_lo_steps", steps - s0, 20);
    check("sat_lo_changes", changes - c0, 15);
    check("sat_lo_dir", cw_steps - e0, 0);

    // Reverse mid-detent
    s0 = steps;
    hold_ab(2'b01, 8); hold_ab(2'b00, 8); hold_ab(2'b01, 8); hold_ab(2'b11, 10);
    check("reverse_steps", steps - s0, 0);
    check("reverse_state", 32'(dut.state), 32'(IDLE));
    check("reverse_freq_sel", freq_sel, 0);

    // Both channels flip together
    hold_ab(2'b00, 10);
    check("jump_state", 32'(dut.state), 32'(ERR));
    hold_ab(2'b11, 10);
    check("jump_idle", 32'(dut.state), 32'(IDLE));
    check("jump_steps", steps - s0, 0);

    // Reset while in CW3
    hold_ab(2'b01, 8); hold_ab(2'b00, 8); hold_ab(2'b10, 10);
    check("cw3_state", 32'(dut.state), 32'(CW3));
    do_reset(1);
    check("cw3_rst_state", 32'(dut.state), 32'(IDLE));
    hold_ab(2'b11, 12);
    check("cw3_rst_steps", steps - s0, 0);
    check("cw3_rst_freq_sel", freq_sel, 1);

    // ena low across a full detent, then one enabled detent
    c0 = changes;
    ena = 1'b0;
    detent(1'b1);
    wait_cyc(4);
    check("ena_freq_sel", freq_sel, 1);
    check("ena_steps", steps - s0, 0);
    check("ena_changes", changes - c0, 0);
    ena = 1'b1;
    detent(1'b1);
    wait_cyc(4);
    check("resume_freq_sel", freq_sel, 2);
    check("resume_steps", steps - s0, 1);

    check("pulse_width", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotary_freq_selector.md
# rotary_freq_selector

Quadrature front end for the random pulse generator: samples the raw rotary-encoder pins, synchronises and debounces them, decodes full detent steps with direction, and maintains a saturating frequency-select value. `freq_sel` feeds the pulse generator's frequency setting, replacing direct `ui_in` driving. `sel_changed` tells the consumer to reload its rate.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required before a debounced level changes; ≥1.
- `SEL_W`, 4: width of `freq_sel`.
- `SEL_MAX`, 15: upper saturation bound; ≤ 2^SEL_W−1.
- `SEL_RESET`, 1: `freq_sel` value after reset; ≤ SEL_MAX.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: when 0, the FSM and `freq_sel` hold; synchronisers and debouncers keep running.
- `clk_in` in 1: encoder channel A, asynchronous.
- `dt_in` in 1: encoder channel B, asynchronous.
- `freq_sel` out SEL_W: current frequency select.
- `step_pulse` out 1: one-cycle pulse per completed detent.
- `step_dir` out 1: 1 = clockwise, 0 = counter-clockwise; valid with `step_pulse`, otherwise holds its last value.
- `sel_changed` out 1: one-cycle pulse when `freq_sel` actually changes.

## Operation
- Each channel passes through a 2-flop synchroniser and then a debouncer.
- Debouncer: when the synchronised level ≠ debounced level, its counter increments. When the counter reaches DEBOUNCE_CYCLES−1 on a mismatching sample, the debounced level takes the new value and the counter clears. Any matching sample clears the counter.
- Counter width: $clog2(DEBOUNCE_CYCLES+1).
- Reset values:
  - synchroniser and debounced levels = 1 (detent level AB=11);
  - counters = 0;
  - FSM = IDLE;
  - `freq_sel` = SEL_RESET;
  - `step_pulse` = 0, `step_dir` = 0, `sel_changed` = 0.
- FSM, on debounced AB:
  - States: IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR.
  - Clockwise sequence: 11→01→00→10→11. Counter-clockwise: 11→10→00→01→11.
  - IDLE: on 01 → CW1; on 10 → CCW1; on 00 → ERR.
  - CWk / CCWk: the expected next code advances one state. The previous code goes back one state (CW1/CCW1 back to IDLE on 11).
  - From CW3 or CCW3, code 11 → IDLE and emits a step (dir 1 or 0 respectively).
  - Code 11 from any other non-IDLE state → IDLE with no step.
  - Any other code (two-bit jump) → ERR.
  - ERR: waits for 11, then → IDLE with no step.
  - The FSM evaluates only when the debounced AB changes; no change means hold.
- Step handling:
  - A step increments `freq_sel` (CW) or decrements it (CCW), saturating at SEL_MAX and at 0.
  - `sel_changed` = 1 only if the value differs; a step at a bound gives `step_pulse` = 1 with `sel_changed` = 0.
- `ena` = 0: the FSM state, `freq_sel`, and the pulse outputs hold at 0. Debounced edges seen while `ena` = 0 are lost. When `ena` returns to 1, the FSM resumes evaluating from the current debounced AB on its next change.
- Reset asserted mid-rotation: everything returns to its reset value next edge, and no step is emitted.

## Timing
- The pin change is first captured at edge 0.
- The synchronised level is valid after edge 1.
- The debounced level changes at edge 1+DEBOUNCE_CYCLES.
- The FSM transition, `step_pulse`, `step_dir`, `freq_sel` update and `sel_changed` all occur on the next edge: 2+DEBOUNCE_CYCLES after capture, all registered together.
- `step_pulse` and `sel_changed` are exactly one cycle wide. Back-to-back steps are at least 2×DEBOUNCE_CYCLES apart by construction.
- A simultaneous change of A and B in the same debounced cycle is a two-bit jump and goes to ERR.

## Structure
- Package `rotary_pkg`:
  - FSM state enum (`IDLE`…`ERR`);
  - direction constants `DIR_CW` = 1, `DIR_CCW` = 0;
  - detent code `DETENT_AB` = 2'b11.
- Sub-module `debounce_sync`: 2-flop synchroniser + debouncer, parameter DEBOUNCE_CYCLES, 1-bit in/out, reset level 1. Instantiated twice.
- The top holds the FSM and the select register.

## Test plan
All tests use DEBOUNCE_CYCLES = 4, SEL_W = 4, SEL_MAX = 15, SEL_RESET = 1.

- **Reset:** assert `rst` 3 cycles → `freq_sel` = 1, all pulses 0, FSM IDLE.
- **One clean CW detent:** AB 01,00,10,11, each held 10 cycles.
  - Exactly one `step_pulse` with `step_dir` = 1.
  - `freq_sel` = 2 and `sel_changed` pulses.
  - The pulse lands 6 cycles after the final 11 edge.
- **Bounce:** A toggles every 2 cycles for 12 cycles then settles at 0 → no debounced change until 4 stable samples; exactly one FSM advance; no spurious step.
- **Saturation:**
  - 16 CW detents from 1 → `freq_sel` = 15; the last two steps give `step_pulse` with no `sel_changed`.
  - Then 20 CCW detents → `freq_sel` = 0.
- **Partial/illegal rotation:**
  - 11→01→00→01→11 (reverse mid-detent) → no step, `freq_sel` unchanged.
  - 11→00 (both channels flip together) → ERR, then 11 → IDLE, no step.
- **Reset and `ena`:**
  - `rst` asserted while in CW3 → no step, `freq_sel` = 1.
  - `ena` = 0 during a full detent → `freq_sel` unchanged, no pulses.
